// File: rtl/flee_rx_sink.sv
// Receive sink for a mesh flee port: duty-cycled ready, flit FIFO, packet framing and counters.
// Define FLEE_RX_CHECK_EN to add the sticky head/body/tail ordering checker and its err output.
module flee_rx_sink #(
  parameter int DW      = 32,
  parameter int DEPTH   = 16,
  parameter int PERIOD  = 16,
  parameter int OPEN_TH = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          throttle_en,
  input  logic [DW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [31:0]   flit_cnt,
  output logic [31:0]   pkt_cnt
`ifdef FLEE_RX_CHECK_EN
  ,
  output logic          err
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_HEAD   = 2'b01;
  localparam logic [1:0] T_TAIL   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [15:0]   r_phase;
  logic [31:0]   r_flit_cnt;
  logic [31:0]   r_pkt_cnt;
  state_t        r_state;
`ifdef FLEE_RX_CHECK_EN
  logic          r_err;
`endif

  logic       w_full;
  logic       w_empty;
  logic       w_open;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_type;
  logic       w_illegal;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Signed compare so a negative OPEN_TH means the window is always open.
  assign w_open  = $signed({16'd0, r_phase}) > OPEN_TH;

  assign ready_o = ~rst & ~w_full & (~throttle_en | w_open);
  assign valid_o = ~w_empty;
  assign data_o  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  assign w_type    = data_i[DW-1:DW-2];
  assign w_illegal = (r_state == S_IDLE)
                     ? ((w_type == T_BODY) || (w_type == T_TAIL))
                     : ((w_type == T_HEAD) || (w_type == T_SINGLE));

  assign flit_cnt = r_flit_cnt;
  assign pkt_cnt  = r_pkt_cnt;
`ifdef FLEE_RX_CHECK_EN
  assign err = r_err;
`endif

  // Storage carries no reset so it can map onto RAM; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_phase  <= '0;
    end else begin
      r_phase <= (r_phase == 16'(PERIOD - 1)) ? 16'd0 : r_phase + 16'd1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Framing: illegal flits still steer the state by their own type so framing resynchronises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
`ifdef FLEE_RX_CHECK_EN
      r_err      <= 1'b0;
`endif
    end else if (w_push) begin
      r_flit_cnt <= r_flit_cnt + 32'd1;
      if (w_type == T_TAIL || w_type == T_SINGLE) r_pkt_cnt <= r_pkt_cnt + 32'd1;
      case (w_type)
        T_HEAD:   r_state <= S_IN_PKT;
        T_TAIL:   r_state <= S_IDLE;
        T_SINGLE: r_state <= S_IDLE;
        default:  r_state <= r_state;
      endcase
`ifdef FLEE_RX_CHECK_EN
      if (w_illegal) r_err <= 1'b1;
`endif
    end
  end

`ifndef FLEE_RX_CHECK_EN
  logic w_unused;
  assign w_unused = w_illegal;
`endif

endmodule

// File: tb/tb_flee_rx_sink.sv
// Directed self-checking bench for flee_rx_sink (DW=32, DEPTH=16, PERIOD=16, OPEN_TH=10).
module tb_flee_rx_sink;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          throttle_en = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [31:0]   flit_cnt;
  logic [31:0]   pkt_cnt;
`ifdef FLEE_RX_CHECK_EN
  logic          err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  flee_rx_sink #(.DW(DW), .DEPTH(16), .PERIOD(16), .OPEN_TH(10)) dut (
    .clk(clk), .rst(rst), .throttle_en(throttle_en),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt)
`ifdef FLEE_RX_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reset spans two cycles and releases on a falling edge; phase is 0 until the next rising edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1 check_eq("rst_ready", 64'(ready_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one flit for one cycle (caller guarantees ready); returns on the following falling edge.
  task automatic push(input logic [DW-1:0] d);
    data_i  = d;
    valid_i = 1'b1;
    #1 check_eq("push_ready", 64'(ready_o), 64'd1);
    @(negedge clk);
    valid_i = 1'b0;
    $display("[TB] push %08h flit_cnt=%0d pkt_cnt=%0d", d, flit_cnt, pkt_cnt);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [DW-1:0] d;

    // 1: back-to-back singles, unthrottled, consumer always ready
    throttle_en = 1'b0;
    ready_i     = 1'b1;
    do_reset();
    #1;
    check_eq("reset_valid_o", 64'(valid_o), 64'd0);
    check_eq("reset_flit_cnt", 64'(flit_cnt), 64'd0);
    check_eq("reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
    for (int i = 0; i < 8; i++) begin
      d = {2'b11, 30'(i + 1)};
      push(d);
      #1;
      check_eq("t1_data_o", 64'(data_o), 64'(d));
      check_eq("t1_valid_o", 64'(valid_o), 64'd1);
    end
    check_eq("t1_flit_cnt", 64'(flit_cnt), 64'd8);
    check_eq("t1_pkt_cnt", 64'(pkt_cnt), 64'd8);

    // 2: duty window, valid held high for 64 cycles from release
    throttle_en = 1'b1;
    data_i      = {2'b11, 30'h55};
    valid_i     = 1'b1;
    do_reset();
    acc = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      check_eq("t2_window", 64'(ready_o), 64'((c % 16) > 10));
      if (ready_o) acc++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    #1;
    check_eq("t2_accepts", 64'(acc), 64'd20);
    check_eq("t2_flit_cnt", 64'(flit_cnt), 64'd20);
    $display("[TB] throttle window accepts=%0d", acc);

    // 3: consumer stalled, fill to full then a single-cycle pop
    throttle_en = 1'b0;
    ready_i     = 1'b0;
    do_reset();
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      data_i  = {2'b11, 30'(c + 100)};
      valid_i = 1'b1;
      #1;
      if (ready_o) acc++;
      @(negedge clk);
    end
    #1;
    check_eq("t3_accepts", 64'(acc), 64'd16);
    check_eq("t3_full_ready", 64'(ready_o), 64'd0);
    check_eq("t3_flit_cnt", 64'(flit_cnt), 64'd16);
    check_eq("t3_head", 64'(data_o), 64'({2'b11, 30'd100}));
    data_i  = {2'b11, 30'd200};
    ready_i = 1'b1;
    #1 check_eq("t3_pop_ready", 64'(ready_o), 64'd0);
    @(negedge clk);
    ready_i = 1'b0;
    #1;
    check_eq("t3_slot_ready", 64'(ready_o), 64'd1);
    check_eq("t3_next_head", 64'(data_o), 64'({2'b11, 30'd101}));
    @(negedge clk);
    #1;
    check_eq("t3_refull_ready", 64'(ready_o), 64'd0);
    check_eq("t3_one_more", 64'(flit_cnt), 64'd17);
    repeat (3) @(negedge clk);
    #1 check_eq("t3_stays", 64'(flit_cnt), 64'd17);
    valid_i = 1'b0;
    $display("[TB] stall test accepts=%0d flit_cnt=%0d", acc, flit_cnt);

    // 4: legal packet H,B,B,T then a single
    ready_i = 1'b1;
    do_reset();
    push({2'b01, 30'h1});
    push({2'b00, 30'h2});
    push({2'b00, 30'h3});
    #1 check_eq("t4_mid_pkt", 64'(pkt_cnt), 64'd0);
    push({2'b10, 30'h4});
    push({2'b11, 30'h5});
    #1;
    check_eq("t4_pkt_cnt", 64'(pkt_cnt), 64'd2);
    check_eq("t4_flit_cnt", 64'(flit_cnt), 64'd5);
`ifdef FLEE_RX_CHECK_EN
    check_eq("t4_err", 64'(err), 64'd0);
`endif

    // 5: body while idle, then a legal packet
    do_reset();
    push({2'b00, 30'h7});
`ifdef FLEE_RX_CHECK_EN
    #1 check_eq("t5_err_set", 64'(err), 64'd1);
`endif
    push({2'b01, 30'h8});
    push({2'b10, 30'h9});
    #1;
    check_eq("t5_pkt_cnt", 64'(pkt_cnt), 64'd1);
    check_eq("t5_flit_cnt", 64'(flit_cnt), 64'd3);
`ifdef FLEE_RX_CHECK_EN
    check_eq("t5_err_sticky", 64'(err), 64'd1);
    do_reset();
    #1 check_eq("t5_err_clr", 64'(err), 64'd0);
`endif

    // 6: reset in the middle of a packet
    do_reset();
    push({2'b01, 30'hA});
    push({2'b00, 30'hB});
    rst = 1'b1;
    #1;
    check_eq("t6_valid_o", 64'(valid_o), 64'd0);
    check_eq("t6_flit_cnt", 64'(flit_cnt), 64'd0);
    check_eq("t6_pkt_cnt", 64'(pkt_cnt), 64'd0);
    check_eq("t6_ready_rst", 64'(ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    push({2'b11, 30'hC});
    #1;
    check_eq("t6_pkt_after", 64'(pkt_cnt), 64'd1);
    check_eq("t6_flit_after", 64'(flit_cnt), 64'd1);
    check_eq("t6_data_o", 64'(data_o), 64'({2'b11, 30'hC}));
`ifdef FLEE_RX_CHECK_EN
    check_eq("t6_err", 64'(err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flee_rx_sink.md
# flee_rx_sink

Synthesizable receive endpoint for a mesh flee (egress) port; the counterpart of the stab-side packet source. Accepts flits over a valid/ready handshake with a programmable back-pressure duty cycle and buffers them in a FIFO for a downstream consumer. Frames packets from the flit type field and counts flits and packets. Optionally checks head/body/tail ordering. Used in the behaviour-model system top wherever a flee port must be drained in hardware instead of by the bench.

## Interface
- DW, 32: flit width; flit type is bits [DW-1:DW-2].
- DEPTH, 16: FIFO depth in flits; power of two, at least 2.
- PERIOD, 16: back-pressure window length in cycles, 1..65535.
- OPEN_TH, 10: ready allowed only when phase > OPEN_TH; OPEN_TH >= PERIOD-1 is legal and means never ready.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- throttle_en  in  1  1: apply the duty window; 0: ready limited only by FIFO space.
- data_i  in  DW  flit from the flee port.
- valid_i  in  1  flit valid.
- ready_o  out  1  sink ready.
- data_o  out  DW  FIFO head flit.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer pops the FIFO head.
- flit_cnt  out  32  accepted flits; wraps at 2^32.
- pkt_cnt  out  32  completed packets (tail or single accepted); wraps.
- err  out  1  sticky protocol error; present only with FLEE_RX_CHECK_EN.

## Operation
- Flit type: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail together).
- Phase counter: counts 0..PERIOD-1, then wraps to 0; runs every cycle regardless of traffic or throttle_en.
- ready_o = ~full & (~throttle_en | (phase > OPEN_TH)).
- Accept: valid_i & ready_o at a rising edge.
  - The flit is written at wr_ptr.
  - flit_cnt increments.
  - pkt_cnt increments if the type is tail or single.
- Pop: valid_o & ready_i. rd_ptr advances.
- FIFO:
  - Pointers are log2(DEPTH)+1 bits.
  - full = MSBs differ and low bits are equal.
  - empty = pointers equal.
  - data_o = mem[rd_ptr], combinational read.
- Simultaneous push and pop:
  - When full: ready_o is 0, so there is no push that cycle; the pop frees one slot, which is visible the next cycle.
  - When empty: valid_o is 0, so there is no pop; the flit appears on data_o the next cycle.
  - Otherwise both occur and occupancy is unchanged.
- Framing FSM, states IDLE and IN_PKT, advancing on accepted flits only:
  - IDLE + head → IN_PKT.
  - IDLE + single → IDLE.
  - IN_PKT + body → IN_PKT.
  - IN_PKT + tail → IDLE.
  - Illegal combinations (IDLE + body or tail; IN_PKT + head or single): the next state follows the flit type as if legal (head → IN_PKT; single or tail → IDLE; body → unchanged), and err is set if the checker is compiled in.
- Reset mid-packet: all state is cleared and partial FIFO contents are discarded. The next flit is interpreted from IDLE.

## Timing
- Reset values:
  - ready_o 0 during reset; after release it is 1 only when throttle_en=0 or OPEN_TH < 0.
  - valid_o 0.
  - data_o = mem[0], don't-care while valid_o=0.
  - flit_cnt 0, pkt_cnt 0, err 0, phase 0, FSM IDLE, pointers 0.
- ready_o is combinational from registered state and throttle_en; it has no path from valid_i.
- Latency data_i → data_o is 1 cycle when the FIFO is empty.
- Throughput is 1 flit/cycle when not throttled.
- Counters and err update on the edge of acceptance.
- Window: with PERIOD=16 and OPEN_TH=10, ready_o is high at phases 11..15, i.e. 5 of every 16 cycles.

## Configuration
- FLEE_RX_CHECK_EN defined:
  - FSM legality checking is active.
  - err goes high the cycle after the first illegal accepted flit.
  - err stays high until rst.
- Not defined:
  - The err port is removed.
  - The FSM still runs, since pkt_cnt depends only on the flit type.

## Test plan
- Reset, throttle_en=0, then 8 single flits back-to-back with ready_i=1:
  - ready_o high on every cycle.
  - data_o matches each flit 1 cycle after acceptance.
  - flit_cnt=8, pkt_cnt=8.
- throttle_en=1, PERIOD=16, OPEN_TH=10, valid_i held high for 64 cycles from reset release:
  - Exactly 20 accepts.
  - Accepts only at phases 11..15.
- ready_i=0 with DEPTH=16:
  - 16 accepts, then ready_o=0.
  - Pulse ready_i for 1 cycle: one pop, then exactly one more accept.
- Packet head, body, body, tail, then single:
  - pkt_cnt=2, flit_cnt=5, err=0.
- With FLEE_RX_CHECK_EN: body in IDLE → err=1 the next cycle; err stays 1 after later legal packets until rst.
- Assert rst after the head and one body of a packet:
  - valid_o=0 and counters 0.
  - A following single flit gives pkt_cnt=1, err=0.
